// File: rtl/mux_sel_arb_pkg.sv
// Shared types and constants for the 2:1 mux-select arbiter.
package mux_sel_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_A = 2'd1,
        ARB_GNT_B = 2'd2
    } arb_state_e;

    // Requester identity, used by the round-robin priority pointer.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    // Mux select encoding: 1 routes leg A, 0 routes leg B.
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // Hold counter width; at least one bit even when the hold limit is disabled.
    function automatic int unsigned cnt_width(input int unsigned max_hold);
        return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mux_sel_hold_cnt.sv
// Saturating hold counter with load-1, clear and an at-limit flag.
// MUX_SEL_ARB_ASSERT_EN exposes the count value for the top-level checks.
module mux_sel_hold_cnt
    import mux_sel_arb_pkg::*;
#(
    parameter int unsigned  MAX_HOLD = 4,
    localparam int unsigned CNT_W    = cnt_width(MAX_HOLD)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic             at_limit_o
`ifdef MUX_SEL_ARB_ASSERT_EN
    ,
    output logic [CNT_W-1:0] cnt_o
`endif
);

    // With no hold limit the counter just saturates at its all-ones value.
    localparam logic [CNT_W-1:0] SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats load, load beats increment; increment stops at SAT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (MAX_HOLD != 0) && (cnt_q == SAT);

`ifdef MUX_SEL_ARB_ASSERT_EN
    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-requester arbiter driving a 2:1 leg-select mux (o_sel=1 -> leg A).
// Round-robin on ties with bounded hold (MAX_HOLD, 0 = unlimited).
// Define MUX_SEL_ARB_ASSERT_EN to compile in runtime consistency checks.
module mux_sel_arbiter
    import mux_sel_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a_req,
    input  logic i_a_last,
    input  logic i_b_req,
    input  logic i_b_last,
    output logic o_a_gnt,
    output logic o_b_gnt,
    output logic o_sel,
    output logic o_busy
);

    arb_state_e state_q, state_d;
    req_id_e    ptr_q, ptr_d;
    logic       a_gnt_q, b_gnt_q, sel_q, busy_q;
    logic       cnt_load, cnt_clr, cnt_inc, at_limit;
    logic       a_rel, b_rel;

`ifdef MUX_SEL_ARB_ASSERT_EN
    localparam int unsigned CNT_W = cnt_width(MAX_HOLD);
    logic [CNT_W-1:0] hold_cnt;
`endif

    mux_sel_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (cnt_load),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .at_limit_o (at_limit)
`ifdef MUX_SEL_ARB_ASSERT_EN
        ,
        .cnt_o      (hold_cnt)
`endif
    );

    // A grant ends when its owner drops, finishes, or overstays while the other side waits.
    assign a_rel = !i_a_req || i_a_last || (at_limit && i_b_req);
    assign b_rel = !i_b_req || i_b_last || (at_limit && i_a_req);

    // Next-state, pointer and counter control.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (i_a_req && i_b_req) begin
                    state_d  = (ptr_q == REQ_A) ? ARB_GNT_A : ARB_GNT_B;
                    cnt_load = 1'b1;
                end else if (i_a_req) begin
                    state_d  = ARB_GNT_A;
                    cnt_load = 1'b1;
                end else if (i_b_req) begin
                    state_d  = ARB_GNT_B;
                    cnt_load = 1'b1;
                end else begin
                    cnt_clr  = 1'b1;
                end
            end
            ARB_GNT_A: begin
                if (!a_rel) begin
                    cnt_inc  = 1'b1;
                end else if (i_b_req) begin
                    state_d  = ARB_GNT_B;
                    ptr_d    = REQ_B;
                    cnt_load = 1'b1;
                end else if (i_a_req && i_a_last) begin
                    // Back-to-back transaction: re-grant without a bubble.
                    cnt_load = 1'b1;
                end else begin
                    state_d  = ARB_IDLE;
                    ptr_d    = REQ_B;
                    cnt_clr  = 1'b1;
                end
            end
            ARB_GNT_B: begin
                if (!b_rel) begin
                    cnt_inc  = 1'b1;
                end else if (i_a_req) begin
                    state_d  = ARB_GNT_A;
                    ptr_d    = REQ_A;
                    cnt_load = 1'b1;
                end else if (i_b_req && i_b_last) begin
                    cnt_load = 1'b1;
                end else begin
                    state_d  = ARB_IDLE;
                    ptr_d    = REQ_A;
                    cnt_clr  = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State and registered outputs; select only moves when a grant is issued.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= REQ_A;
            a_gnt_q <= 1'b0;
            b_gnt_q <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= SEL_B;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_gnt_q <= (state_d == ARB_GNT_A);
            b_gnt_q <= (state_d == ARB_GNT_B);
            busy_q  <= (state_d != ARB_IDLE);
            if (state_d == ARB_GNT_A) begin
                sel_q <= SEL_A;
            end else if (state_d == ARB_GNT_B) begin
                sel_q <= SEL_B;
            end
`ifdef MUX_SEL_ARB_ASSERT_EN
            assert (!(a_gnt_q && b_gnt_q))
                else $error("both grants high: state=%0d cnt=%0d", state_q, hold_cnt);
            assert (!a_gnt_q || (sel_q == SEL_A))
                else $error("A granted but sel=%0b: state=%0d cnt=%0d", sel_q, state_q, hold_cnt);
            assert (!b_gnt_q || (sel_q == SEL_B))
                else $error("B granted but sel=%0b: state=%0d cnt=%0d", sel_q, state_q, hold_cnt);
            assert (!((state_d == ARB_GNT_A) && !a_gnt_q) || i_a_req)
                else $error("A granted without request: state=%0d cnt=%0d", state_q, hold_cnt);
            assert (!((state_d == ARB_GNT_B) && !b_gnt_q) || i_b_req)
                else $error("B granted without request: state=%0d cnt=%0d", state_q, hold_cnt);
            assert ((MAX_HOLD == 0) || (hold_cnt <= CNT_W'(MAX_HOLD)))
                else $error("hold count over limit: state=%0d cnt=%0d", state_q, hold_cnt);
`endif
        end
    end

    assign o_a_gnt = a_gnt_q;
    assign o_b_gnt = b_gnt_q;
    assign o_sel   = sel_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: a vector table for the main sequences plus
// hand-written sequences for unlimited hold and asynchronous reset.
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_req = 1'b0, a_last = 1'b0, b_req = 1'b0, b_last = 1'b0;

    logic a_gnt, b_gnt, sel, busy;
    logic n_a_gnt, n_b_gnt, n_sel, n_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_a_req  (a_req),
        .i_a_last (a_last),
        .i_b_req  (b_req),
        .i_b_last (b_last),
        .o_a_gnt  (a_gnt),
        .o_b_gnt  (b_gnt),
        .o_sel    (sel),
        .o_busy   (busy)
    );

    mux_sel_arbiter #(
        .MAX_HOLD (0)
    ) dut_nolim (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_a_req  (a_req),
        .i_a_last (a_last),
        .i_b_req  (b_req),
        .i_b_last (b_last),
        .o_a_gnt  (n_a_gnt),
        .o_b_gnt  (n_b_gnt),
        .o_sel    (n_sel),
        .o_busy   (n_busy)
    );

    // Expected outputs packed as {a_gnt, b_gnt, sel, busy}.
    localparam logic [3:0] GA = 4'b1011;
    localparam logic [3:0] GB = 4'b0101;
    localparam logic [3:0] I1 = 4'b0010;
    localparam logic [3:0] I0 = 4'b0000;

    typedef struct {
        logic       a_req;
        logic       a_last;
        logic       b_req;
        logic       b_last;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ar, input logic al, input logic br, input logic bl,
                                input logic [3:0] e, input string n);
        vec_t v;
        v.a_req = ar; v.a_last = al; v.b_req = br; v.b_last = bl; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {a_gnt,b_gnt,sel,busy}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ar, input logic al, input logic br, input logic bl);
        a_req = ar; a_last = al; b_req = br; b_last = bl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Tie: round robin with 4-cycle hold limit.
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, GA, "tie_a_hold");
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, GB, "tie_b_hold");
        add(1, 0, 1, 0, GA, "tie_back_to_a");
        add(0, 0, 1, 0, GB, "a_drop_b_takes");
        add(0, 0, 0, 0, I0, "b_drop_idle_sel0");
        // Single requester, drop -> idle with select held on leg A.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, GA, "single_a");
        add(0, 0, 0, 0, I1, "a_drop_idle_sel1");
        // Re-grant on last with request held; counter restarts at 1.
        add(1, 0, 0, 0, GA, "regrant_first");
        add(1, 1, 0, 0, GA, "regrant_last");
        add(1, 0, 0, 0, GA, "regrant_cnt2");
        add(1, 0, 1, 0, GA, "regrant_cnt3");
        add(1, 0, 1, 0, GA, "regrant_cnt4");
        add(1, 0, 1, 0, GB, "regrant_limit_to_b");
        add(0, 0, 1, 1, GB, "b_regrant_last");
        add(0, 0, 0, 0, I0, "b_done_idle");
        // Withdrawn B request while A holds: B is never granted.
        add(1, 0, 0, 0, GA, "wd_a_grant");
        add(1, 0, 1, 0, GA, "wd_b_pulse");
        add(1, 0, 0, 0, GA, "wd_b_gone");
        add(0, 0, 0, 0, I1, "wd_a_drop");
        add(0, 0, 0, 0, I1, "wd_idle_stays");
        // Pointer now on B; limit and last coincide -> single release.
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, GB, "ptr_b_hold");
        add(1, 0, 1, 1, GA, "limit_and_last");
        add(0, 0, 0, 0, I1, "idle_after_a");
        // Request drop together with last -> single release to idle.
        add(1, 0, 0, 0, GA, "droplast_grant");
        add(0, 1, 0, 0, I1, "droplast_release");

        do_reset();
        check("reset_state", {a_gnt, b_gnt, sel, busy}, I0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a_req, vecs[i].a_last, vecs[i].b_req, vecs[i].b_last);
            tick();
            check($sformatf("%s[%0d]", vecs[i].name, i), {a_gnt, b_gnt, sel, busy}, vecs[i].exp);
        end

        // Unlimited hold: A keeps the leg until it signals last.
        do_reset();
        check("nolim_reset", {n_a_gnt, n_b_gnt, n_sel, n_busy}, I0);
        drive(1, 0, 1, 0);
        for (int i = 0; i < 18; i++) begin
            tick();
            check($sformatf("nolim_hold[%0d]", i), {n_a_gnt, n_b_gnt, n_sel, n_busy}, GA);
        end
        drive(1, 1, 1, 0);
        tick();
        check("nolim_last_to_b", {n_a_gnt, n_b_gnt, n_sel, n_busy}, GB);

        // Asynchronous reset mid-grant of B.
        do_reset();
        drive(0, 0, 1, 0);
        tick();
        check("pre_rst_gnt_b", {a_gnt, b_gnt, sel, busy}, GB);
        drive(1, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_drop", {a_gnt, b_gnt, sel, busy}, I0);
        tick();
        check("rst_held_edge", {a_gnt, b_gnt, sel, busy}, I0);
        rst = 1'b0;
        tick();
        check("post_rst_a_first", {a_gnt, b_gnt, sel, busy}, GA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
